// File: rtl/if_id_pipeline_register_pkg.sv
// Shared constants and types for the SPARC IF/ID pipeline register:
// bubble encoding, Bicc opcode fields, annul-bit index and delay-slot FSM states.
package if_id_pipeline_register_pkg;

  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0100_0000;  // sethi 0,%g0
  localparam logic [1:0]  OP_BRANCH        = 2'b00;
  localparam logic [2:0]  OP2_BICC         = 3'b010;
  localparam int          ANNUL_BIT        = 29;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLOT  = 2'd1,
    ANNUL = 2'd2
  } slot_state_t;

  function automatic logic is_bicc(input logic [31:0] instr);
    return (instr[31:30] == OP_BRANCH) && (instr[24:22] == OP2_BICC);
  endfunction

endpackage

// File: rtl/if_id_pipeline_register_delay_slot_fsm.sv
// Delay-slot tracker: decides whether the next valid instruction entering ID is
// a plain, delay-slot or annulled-slot instruction, and registers ID_in_delay_slot.
module if_id_pipeline_register_delay_slot_fsm
  import if_id_pipeline_register_pkg::*;
(
  input  logic clk,
  input  logic i_reset,
  input  logic i_load_enable,
  input  logic i_flush,
  input  logic i_if_valid,
  input  logic i_branch_instr,
  input  logic i_annul_bit,
  input  logic i_branch_taken,
  input  logic i_branch_always,
  output logic o_annul_load,
  output logic o_in_delay_slot
);

  slot_state_t r_state;
  slot_state_t w_state_next;
  slot_state_t w_target;
  slot_state_t w_class;
  logic        r_in_delay_slot;

  // r_state is the slot class still owed to the next valid instruction; it only
  // leaves RUN when a bubble loads in place of the slot.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state         <= RUN;
      r_in_delay_slot <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (i_flush)
        r_in_delay_slot <= 1'b0;
      else if (i_load_enable)
        r_in_delay_slot <= i_if_valid && (w_class != RUN);
    end
  end

  always_comb begin
    w_target     = RUN;
    w_class      = RUN;
    w_state_next = r_state;
    o_annul_load = 1'b0;

    if (i_branch_instr)
      w_target = (i_annul_bit && (!i_branch_taken || i_branch_always)) ? ANNUL : SLOT;

    w_class = (r_state == RUN) ? w_target : r_state;

    if (i_flush)
      w_state_next = RUN;
    else if (i_load_enable)
      w_state_next = i_if_valid ? RUN : w_class;

    o_annul_load = i_if_valid && (w_class == ANNUL);
  end

  assign o_in_delay_slot = r_in_delay_slot;

endmodule

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register with branch delay-slot annulment, stall and flush.
// Optional IF_ID_ANNUL_COUNT_EN adds a saturating annulled-slot counter output.
module if_id_pipeline_register
  import if_id_pipeline_register_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_enable,
  input  logic        flush,
  input  logic [31:0] IF_instr,
  input  logic [31:0] IF_pc,
  input  logic [31:0] IF_npc,
  input  logic        IF_valid,
  input  logic        branch_taken,
  input  logic        branch_always,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_npc,
  output logic        ID_valid,
  output logic        ID_branch_instr,
  output logic        a,
  output logic        ID_in_delay_slot
`ifdef IF_ID_ANNUL_COUNT_EN
  ,
  output logic [15:0] annul_count
`endif
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic        r_valid;
  logic        w_annul_load;
  logic        w_branch_instr;

  assign w_branch_instr = r_valid && is_bicc(r_instr);

  if_id_pipeline_register_delay_slot_fsm u_delay_slot_fsm (
    .clk             (clk),
    .i_reset         (reset),
    .i_load_enable   (load_enable),
    .i_flush         (flush),
    .i_if_valid      (IF_valid),
    .i_branch_instr  (w_branch_instr),
    .i_annul_bit     (r_instr[ANNUL_BIT]),
    .i_branch_taken  (branch_taken),
    .i_branch_always (branch_always),
    .o_annul_load    (w_annul_load),
    .o_in_delay_slot (ID_in_delay_slot)
  );

  // PC/nPC follow load_enable even during a flush so the bubble carries a sane PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= NOP_WORD;
      r_pc    <= PC_RESET;
      r_npc   <= PC_RESET + 32'd4;
      r_valid <= 1'b0;
    end else begin
      if (load_enable) begin
        r_pc  <= IF_pc;
        r_npc <= IF_npc;
      end
      if (flush) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (load_enable) begin
        r_instr <= w_annul_load ? NOP_WORD : IF_instr;
        r_valid <= IF_valid && !w_annul_load;
      end
    end
  end

`ifdef IF_ID_ANNUL_COUNT_EN
  logic [15:0] r_annul_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_annul_count <= 16'd0;
    else if (load_enable && !flush && w_annul_load && (r_annul_count != 16'hFFFF))
      r_annul_count <= r_annul_count + 16'd1;
  end

  assign annul_count = r_annul_count;
`endif

  assign ID_instr        = r_instr;
  assign ID_pc           = r_pc;
  assign ID_npc          = r_npc;
  assign ID_valid        = r_valid;
  assign ID_branch_instr = w_branch_instr;
  assign a               = w_branch_instr && r_instr[ANNUL_BIT];

endmodule

// File: tb/tb_if_id_pipeline_register.sv
// Directed self-checking bench for if_id_pipeline_register: reset, delay slots,
// annulment, stall, flush, bubbles and (with IF_ID_ANNUL_COUNT_EN) the annul counter.
module tb_if_id_pipeline_register;

  localparam logic [31:0] NOP    = 32'h0100_0000;
  localparam logic [31:0] BNE    = 32'h1280_0004;
  localparam logic [31:0] BNE_A  = 32'h3280_0004;
  localparam logic [31:0] BA_A   = 32'h3080_0004;
  localparam logic [31:0] ADD1   = 32'h8200_0001;
  localparam logic [31:0] ADD2   = 32'h8400_0002;

  logic        clk;
  logic        reset;
  logic        load_enable;
  logic        flush;
  logic [31:0] IF_instr;
  logic [31:0] IF_pc;
  logic [31:0] IF_npc;
  logic        IF_valid;
  logic        branch_taken;
  logic        branch_always;
  logic [31:0] ID_instr;
  logic [31:0] ID_pc;
  logic [31:0] ID_npc;
  logic        ID_valid;
  logic        ID_branch_instr;
  logic        a;
  logic        ID_in_delay_slot;
`ifdef IF_ID_ANNUL_COUNT_EN
  logic [15:0] annul_count;
`endif

  int n_checks;
  int n_pass;

  if_id_pipeline_register dut (
    .clk              (clk),
    .reset            (reset),
    .load_enable      (load_enable),
    .flush            (flush),
    .IF_instr         (IF_instr),
    .IF_pc            (IF_pc),
    .IF_npc           (IF_npc),
    .IF_valid         (IF_valid),
    .branch_taken     (branch_taken),
    .branch_always    (branch_always),
    .ID_instr         (ID_instr),
    .ID_pc            (ID_pc),
    .ID_npc           (ID_npc),
    .ID_valid         (ID_valid),
    .ID_branch_instr  (ID_branch_instr),
    .a                (a),
    .ID_in_delay_slot (ID_in_delay_slot)
`ifdef IF_ID_ANNUL_COUNT_EN
    ,
    .annul_count      (annul_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-14s obs=%08h exp=%08h", tag, obs, exp);
    end else begin
      $display("FAIL %-14s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction at IF and clock it into ID.
  task automatic load(input logic [31:0] instr, input logic [31:0] pc, input logic valid);
    IF_instr    = instr;
    IF_pc       = pc;
    IF_npc      = pc + 32'd4;
    IF_valid    = valid;
    load_enable = 1'b1;
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    load_enable   = 1'b1;
    flush         = 1'b0;
    IF_instr      = ADD1;
    IF_pc         = 32'h100;
    IF_npc        = 32'h104;
    IF_valid      = 1'b1;
    branch_taken  = 1'b0;
    branch_always = 1'b0;

    tick();
    check("rst_instr", ID_instr, NOP);
    check("rst_pc", ID_pc, 32'h0);
    check("rst_npc", ID_npc, 32'h4);
    check("rst_valid", ID_valid, 1'b0);
    check("rst_slot", ID_in_delay_slot, 1'b0);
    check("rst_br", ID_branch_instr, 1'b0);
    reset = 1'b0;

    // Taken BNE, a=0: slot executes.
    branch_taken = 1'b1;
    load(BNE, 32'h10, 1'b1);
    check("bne_instr", ID_instr, BNE);
    check("bne_br", ID_branch_instr, 1'b1);
    check("bne_a", a, 1'b0);
    check("bne_slot", ID_in_delay_slot, 1'b0);
    load(ADD1, 32'h14, 1'b1);
    check("s1_instr", ID_instr, ADD1);
    check("s1_valid", ID_valid, 1'b1);
    check("s1_slot", ID_in_delay_slot, 1'b1);
    check("s1_br", ID_branch_instr, 1'b0);
    load(ADD2, 32'h18, 1'b1);
    check("s1_after", ID_in_delay_slot, 1'b0);

    // Untaken BNE,a: slot annulled.
    branch_taken = 1'b0;
    load(BNE_A, 32'h20, 1'b1);
    check("bnea_a", a, 1'b1);
    load(ADD1, 32'h24, 1'b1);
    check("an1_instr", ID_instr, NOP);
    check("an1_valid", ID_valid, 1'b0);
    check("an1_slot", ID_in_delay_slot, 1'b1);
    check("an1_pc", ID_pc, 32'h24);
    check("an1_npc", ID_npc, 32'h28);
    check("an1_br", ID_branch_instr, 1'b0);
    load(ADD2, 32'h28, 1'b1);
    check("an1_after", ID_in_delay_slot, 1'b0);
    check("an1_nxt_v", ID_valid, 1'b1);
    check("an1_nxt_i", ID_instr, ADD2);

    // BA,a taken, stalled 3 cycles before the slot loads.
    branch_taken  = 1'b1;
    branch_always = 1'b1;
    load(BA_A, 32'h30, 1'b1);
    load_enable = 1'b0;
    IF_instr    = ADD1;
    IF_pc       = 32'h34;
    IF_npc      = 32'h38;
    for (int i = 0; i < 3; i++) tick();
    check("stl_instr", ID_instr, BA_A);
    check("stl_pc", ID_pc, 32'h30);
    check("stl_br", ID_branch_instr, 1'b1);
    check("stl_slot", ID_in_delay_slot, 1'b0);
    load(ADD1, 32'h34, 1'b1);
    check("ba_instr", ID_instr, NOP);
    check("ba_valid", ID_valid, 1'b0);
    check("ba_slot", ID_in_delay_slot, 1'b1);
    branch_taken  = 1'b0;
    branch_always = 1'b0;
    load(ADD2, 32'h38, 1'b1);
    check("ba_after", ID_in_delay_slot, 1'b0);

    // Flush with an annul pending.
    load(BNE_A, 32'h40, 1'b1);
    flush = 1'b1;
    load(ADD1, 32'h44, 1'b1);
    flush = 1'b0;
    check("fl_instr", ID_instr, NOP);
    check("fl_valid", ID_valid, 1'b0);
    check("fl_slot", ID_in_delay_slot, 1'b0);
    check("fl_pc", ID_pc, 32'h44);
    load(ADD2, 32'h48, 1'b1);
    check("fl_nxt_i", ID_instr, ADD2);
    check("fl_nxt_v", ID_valid, 1'b1);
    check("fl_nxt_s", ID_in_delay_slot, 1'b0);

    // DCTI couple: slot is itself an annulling branch, untaken.
    branch_taken = 1'b1;
    load(BNE, 32'h50, 1'b1);
    branch_taken = 1'b0;
    load(BNE_A, 32'h54, 1'b1);
    check("dc_slot", ID_in_delay_slot, 1'b1);
    check("dc_br", ID_branch_instr, 1'b1);
    check("dc_a", a, 1'b1);
    load(ADD1, 32'h58, 1'b1);
    check("dc2_instr", ID_instr, NOP);
    check("dc2_valid", ID_valid, 1'b0);
    check("dc2_slot", ID_in_delay_slot, 1'b1);
    load(ADD2, 32'h5C, 1'b1);
    check("dc3_slot", ID_in_delay_slot, 1'b0);

    // Bubble where the slot is due: the slot mark waits for the real instruction.
    branch_taken = 1'b1;
    load(BNE, 32'h60, 1'b1);
    load(ADD1, 32'h64, 1'b0);
    check("bub_valid", ID_valid, 1'b0);
    check("bub_instr", ID_instr, ADD1);
    check("bub_slot", ID_in_delay_slot, 1'b0);
    load(ADD2, 32'h64, 1'b1);
    check("bub2_valid", ID_valid, 1'b1);
    check("bub2_slot", ID_in_delay_slot, 1'b1);
    load(ADD1, 32'h68, 1'b1);
    check("bub3_slot", ID_in_delay_slot, 1'b0);

`ifdef IF_ID_ANNUL_COUNT_EN
    check("cnt_3", annul_count, 32'd3);
`endif

    // Reset dominates load and flush.
    reset = 1'b1;
    flush = 1'b1;
    load(ADD2, 32'h70, 1'b1);
    reset = 1'b0;
    flush = 1'b0;
    check("rst2_instr", ID_instr, NOP);
    check("rst2_pc", ID_pc, 32'h0);
    check("rst2_npc", ID_npc, 32'h4);
    check("rst2_valid", ID_valid, 1'b0);
`ifdef IF_ID_ANNUL_COUNT_EN
    check("cnt_rst", annul_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_pipeline_register.md
Name: if_id_pipeline_register

Overview:
- IF/ID pipeline register for the SPARC pipeline: latches the fetched instruction, PC and nPC into the ID stage.
- Tracks the branch delay slot and annuls it when the branch's annul bit requires it.
- Produces the ID_branch_instr/a context that the downstream reset/flush logic consumes.
- Holds on stall; accepts a flush that inserts a bubble.

Parameters:
- NOP_WORD, 32'h0100_0000, bubble encoding (sethi 0,%g0).
- PC_RESET, 32'h0000_0000, ID_pc value after reset; ID_npc resets to PC_RESET+4.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; dominates every other input.
- load_enable  input  1  1 = advance; 0 = stall (hold all state).
- flush  input  1  synchronous bubble insert (driven from reset_out of the reset handler).
- IF_instr  input  32  fetched instruction word.
- IF_pc  input  32  PC of IF_instr.
- IF_npc  input  32  nPC of IF_instr.
- IF_valid  input  1  IF_instr is real.
- branch_taken  input  1  ID-stage branch condition result, valid with ID_branch_instr.
- branch_always  input  1  ID branch is BA (unconditional).
- ID_instr  output  32  registered instruction.
- ID_pc  output  32  registered PC.
- ID_npc  output  32  registered nPC.
- ID_valid  output  1  ID_instr is to execute.
- ID_branch_instr  output  1  ID_instr is Bicc (op=00, op2=010) and ID_valid.
- a  output  1  annul bit (ID_instr[29]) when ID_branch_instr, else 0.
- ID_in_delay_slot  output  1  ID holds a delay-slot instruction (annulled or not).

Behaviour:
- Reset values: ID_instr=NOP_WORD, ID_pc=PC_RESET, ID_npc=PC_RESET+4, ID_valid=0, ID_in_delay_slot=0, FSM=RUN.
- Latency: one cycle from IF inputs to ID outputs when load_enable=1.
- Priority, per edge: reset > flush > stall (load_enable=0) > normal load.
- flush: loads NOP_WORD, ID_valid=0, ID_in_delay_slot=0, FSM=RUN. PC/nPC still load from IF if load_enable=1, otherwise hold.
- Stall: every register and the FSM hold, including a pending annul decision.
- FSM states:
  - RUN: normal loading. On load, if the current ID_branch_instr=1, go to SLOT, or to ANNUL when the annul rule holds.
  - SLOT: the loaded instruction is the delay slot. ID_in_delay_slot=1 with ID_valid=IF_valid. Return to RUN on the next load.
  - ANNUL: the loaded instruction is the delay slot. ID_instr=NOP_WORD, ID_valid=0, ID_in_delay_slot=1, PC/nPC loaded normally. Return to RUN on the next load.
- Annul rule: a=1 AND (branch_taken=0 OR branch_always=1), both sampled with the branch in ID at the loading edge.
- Branch in delay slot (DCTI couple): the slot instruction's own branch is evaluated on the next load, so SLOT can go directly to SLOT or ANNUL. An annulled slot never triggers a transition.
- IF_valid=0 on a load: ID_valid=0, with instr/pc still latched. Such a bubble does not consume a pending slot state; the FSM holds until a valid instruction loads.
- Reset or flush in SLOT/ANNUL: the pending slot is discarded, FSM=RUN.
- ID_branch_instr and a are combinational from the registered ID_instr and ID_valid.

Optional Feature:
- Macro: IF_ID_ANNUL_COUNT_EN.
- With it defined: adds output annul_count [15:0], a saturating counter (holds at 16'hFFFF). It increments on each load into ANNUL and clears on reset; flush does not clear it.
- Without it: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/header: NOP_WORD; Bicc opcode fields (OP_BRANCH=2'b00, OP2_BICC=3'b010); FSM state encodings RUN/SLOT/ANNUL (2-bit); annul bit index 29.
- One natural sub-module: delay_slot_fsm, which owns the state, the annul rule and ID_in_delay_slot. The datapath registers stay in the top level.

Test Plan:
- Reset: assert reset for 1 clk with IF_instr=32'h8200_0001, load_enable=1 -> ID_instr=32'h0100_0000, ID_pc=0, ID_npc=4, ID_valid=0.
- Taken non-annulling branch: load BNE (a=0, 32'h1280_0004), branch_taken=1, then load 32'h8200_0001 -> the slot instruction has ID_valid=1 and ID_in_delay_slot=1.
- Untaken annulling branch: load BNE,a (32'h3280_0004), branch_taken=0 -> next ID_instr=NOP_WORD, ID_valid=0, ID_in_delay_slot=1; the following load gives ID_in_delay_slot=0.
- BA,a with branch_taken=1 and branch_always=1 -> slot annulled. Stall 3 cycles between the branch and the slot load -> the annul is still applied after the stall.
- Flush while FSM=ANNUL pending -> ID_valid=0 and the FSM returns to RUN; the next valid instruction loads with ID_valid=1 and ID_in_delay_slot=0.
- With IF_ID_ANNUL_COUNT_EN: 3 annulled slots -> annul_count=3; reset -> 0.
